// File: rtl/vm1_qslave_if.sv
// Qbus pin bundle between a bus master and the vm1_qslave register/interrupt slave.
// Active-high core-side signals with separate in/out/ena wiring, as on the vm1 core.
interface vm1_qslave_if;
    logic        pin_init;
    logic [15:0] pin_ad_in;
    logic [15:0] pin_ad_out;
    logic        pin_ad_ena;
    logic        pin_sync_in;
    logic        pin_din_in;
    logic        pin_dout_in;
    logic        pin_wtbt_in;
    logic        pin_rply_out;
    logic        pin_virq_out;
    logic        pin_iako_in;
    logic        pin_iako_out;

    modport master (
        output pin_init, pin_ad_in, pin_sync_in, pin_din_in,
        output pin_dout_in, pin_wtbt_in, pin_iako_in,
        input  pin_ad_out, pin_ad_ena, pin_rply_out,
        input  pin_virq_out, pin_iako_out
    );

    modport slave (
        input  pin_init, pin_ad_in, pin_sync_in, pin_din_in,
        input  pin_dout_in, pin_wtbt_in, pin_iako_in,
        output pin_ad_out, pin_ad_ena, pin_rply_out,
        output pin_virq_out, pin_iako_out
    );
endinterface

// File: rtl/vm1_qslave.sv
// vm1 Qbus slave: NREG word registers with word/byte access and delayed RPLY,
// plus a vectored interrupt requester with IAKO daisy-chain pass-through.
module vm1_qslave #(
    parameter logic [15:0] BASE     = 16'o177700,
    parameter int          NREG     = 4,
    parameter logic [15:0] VECTOR   = 16'o000100,
    parameter int          RPLY_DLY = 1
) (
    input  logic               pin_clk,
    input  logic               pin_dclo,
    vm1_qslave_if.slave        bus,
    input  logic               irq_req,
    output logic [16*NREG-1:0] reg_q,
    output logic [NREG-1:0]    reg_wstb
);
    localparam int          K   = $clog2(NREG) + 1;
    localparam int          IW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [2:0]  DLY = 3'(RPLY_DLY);

    typedef enum logic [2:0] {IDLE, SEL, WAIT, REPLY, HOLD} bus_st_t;
    typedef enum logic [1:0] {IRQ_IDLE, PEND, ACK, PASS} irq_st_t;

    bus_st_t     bstate, bnext;
    irq_st_t     istate, inext;

    logic        s_sync, s_sync_d, s_din, s_dout, s_wtbt;
    logic        s_iako, s_iako_d, s_irq, s_irq_d;
    logic [15:0] s_ad;

    logic [15:0] adr;
    logic [15:0] rdata;
    logic [15:0] regs [NREG];
    logic [2:0]  cnt, icnt;
    logic        op_rd;
    logic        pending;
    logic        irply;

    logic        sync_rise, iako_rise, irq_rise;
    logic        sel_in, strobe, claim;
    logic        brply, bena;
    logic [IW-1:0] idx;

    assign sync_rise = s_sync & ~s_sync_d;
    assign iako_rise = s_iako & ~s_iako_d;
    assign irq_rise  = s_irq & ~s_irq_d;
    assign sel_in    = (s_ad >> K) == (BASE >> K);
    assign idx       = IW'((adr >> 1) & 16'(NREG - 1));
    assign strobe    = op_rd ? s_din : s_dout;
    assign claim     = pending & s_din & ~s_sync;

    // Register every bus input once; edge detectors use the delayed copies.
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            s_sync   <= 1'b0;
            s_sync_d <= 1'b0;
            s_din    <= 1'b0;
            s_dout   <= 1'b0;
            s_wtbt   <= 1'b0;
            s_iako   <= 1'b0;
            s_iako_d <= 1'b0;
            s_irq    <= 1'b0;
            s_irq_d  <= 1'b0;
            s_ad     <= 16'h0;
        end else begin
            s_sync   <= bus.pin_sync_in;
            s_sync_d <= s_sync;
            s_din    <= bus.pin_din_in;
            s_dout   <= bus.pin_dout_in;
            s_wtbt   <= bus.pin_wtbt_in;
            s_iako   <= bus.pin_iako_in;
            s_iako_d <= s_iako;
            s_irq    <= irq_req;
            s_irq_d  <= s_irq;
            s_ad     <= bus.pin_ad_in;
        end
    end

    // State registers for the bus and interrupt FSMs.
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            bstate <= IDLE;
            istate <= IRQ_IDLE;
        end else begin
            bstate <= bnext;
            istate <= inext;
        end
    end

    // Bus FSM next state; losing SYNC aborts from any state.
    always_comb begin
        bnext = bstate;
        if (bus.pin_init) begin
            bnext = IDLE;
        end else if (bstate == IDLE) begin
            if (sync_rise && sel_in)
                bnext = SEL;
        end else if (!s_sync) begin
            bnext = IDLE;
        end else begin
            unique case (bstate)
                SEL:     if (s_din || s_dout) bnext = WAIT;
                WAIT:    if (cnt == 3'd0) bnext = REPLY;
                REPLY:   bnext = HOLD;
                HOLD:    if (!strobe) bnext = SEL;
                default: bnext = IDLE;
            endcase
        end
    end

    // Interrupt FSM next state; the claim/pass decision is made on the IAKO edge.
    always_comb begin
        inext = istate;
        if (bus.pin_init) begin
            inext = IRQ_IDLE;
        end else begin
            unique case (istate)
                IRQ_IDLE, PEND: begin
                    if (iako_rise)
                        inext = claim ? ACK : PASS;
                    else if (pending)
                        inext = PEND;
                end
                ACK:     if (!s_din) inext = IRQ_IDLE;
                PASS:    if (!s_iako) inext = pending ? PEND : IRQ_IDLE;
                default: inext = IRQ_IDLE;
            endcase
        end
    end

    // Address latch, reply delay and register access on entry to REPLY.
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            adr      <= 16'h0;
            rdata    <= 16'h0;
            cnt      <= 3'd0;
            op_rd    <= 1'b0;
            reg_wstb <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= 16'h0;
        end else if (bus.pin_init) begin
            adr      <= 16'h0;
            rdata    <= 16'h0;
            cnt      <= 3'd0;
            op_rd    <= 1'b0;
            reg_wstb <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= 16'h0;
        end else begin
            reg_wstb <= '0;
            if (bstate == IDLE && sync_rise)
                adr <= s_ad;
            if (bstate == SEL && bnext == WAIT) begin
                cnt   <= DLY;
                op_rd <= s_din;
            end else if (bstate == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (bstate == WAIT && bnext == REPLY) begin
                if (op_rd) begin
                    rdata <= regs[idx];
                end else begin
                    reg_wstb[idx] <= 1'b1;
                    if (!s_wtbt)
                        regs[idx] <= s_ad;
                    else if (adr[0])
                        regs[idx][15:8] <= s_ad[15:8];
                    else
                        regs[idx][7:0] <= s_ad[7:0];
                end
            end
        end
    end

    // Pending flag (a new request beats the acknowledge clear) and ACK reply.
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            pending <= 1'b0;
            icnt    <= 3'd0;
            irply   <= 1'b0;
        end else if (bus.pin_init) begin
            pending <= 1'b0;
            icnt    <= 3'd0;
            irply   <= 1'b0;
        end else begin
            if (irq_rise)
                pending <= 1'b1;
            else if (istate == ACK && !s_din)
                pending <= 1'b0;
            if (istate != ACK && inext == ACK)
                icnt <= DLY;
            else if (istate == ACK && icnt != 3'd0)
                icnt <= icnt - 3'd1;
            irply <= (istate == ACK) && (inext == ACK) && (icnt == 3'd0);
        end
    end

    // Flatten the register file onto reg_q.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NREG; i++)
            reg_q[16*i +: 16] = regs[i];
    end

    assign brply = (bstate == REPLY) || (bstate == HOLD);
    assign bena  = brply & op_rd;

    assign bus.pin_rply_out = brply | irply;
    assign bus.pin_ad_ena   = bena | irply;
    assign bus.pin_ad_out   = bena  ? rdata  :
                              irply ? VECTOR : 16'h0;
    assign bus.pin_virq_out = pending;
    assign bus.pin_iako_out = s_iako &
        ((istate == PASS) ||
         ((istate == IRQ_IDLE || istate == PEND) && iako_rise && !claim));
endmodule

// File: tb/tb_vm1_qslave.sv
// Directed self-checking bench for vm1_qslave (NREG=4, BASE=177700, RPLY_DLY=1).
// Inputs change 1ns after the rising edge; outputs are sampled there as well.
module tb_vm1_qslave;
    localparam int DLY = 1;
    localparam int LAT = 3 + DLY;

    logic        clk = 1'b0;
    logic        dclo;
    logic        irq_req;
    logic [63:0] reg_q;
    logic [3:0]  reg_wstb;

    int          checks = 0;
    int          errors = 0;
    int          n, n2;
    logic [15:0] d;
    logic        e;
    logic [3:0]  ws0, ws1;
    logic        seen;

    vm1_qslave_if bus();

    vm1_qslave #(
        .BASE(16'o177700), .NREG(4), .VECTOR(16'o000100), .RPLY_DLY(DLY)
    ) dut (
        .pin_clk(clk), .pin_dclo(dclo), .bus(bus),
        .irq_req(irq_req), .reg_q(reg_q), .reg_wstb(reg_wstb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rply(input logic want, output int cnt);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.pin_rply_out === want) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] v,
                            input logic bw, output int cnt,
                            output logic [3:0] w0, output logic [3:0] w1);
        int m;
        bus.pin_ad_in   = a;
        bus.pin_wtbt_in = bw;
        bus.pin_sync_in = 1'b1;
        tick();
        tick();
        bus.pin_ad_in   = v;
        bus.pin_dout_in = 1'b1;
        wait_rply(1'b1, cnt);
        w0 = reg_wstb;
        tick();
        w1 = reg_wstb;
        bus.pin_dout_in = 1'b0;
        wait_rply(1'b0, m);
        chk("wr_rply_drop", 32'(m != 0), 32'd1);
        bus.pin_sync_in = 1'b0;
        bus.pin_wtbt_in = 1'b0;
        bus.pin_ad_in   = 16'h0;
        tick();
        tick();
    endtask

    task automatic do_read(input logic [15:0] a, output int cnt,
                           output logic [15:0] v, output logic en);
        int m;
        bus.pin_ad_in   = a;
        bus.pin_sync_in = 1'b1;
        tick();
        tick();
        bus.pin_ad_in  = 16'h0;
        bus.pin_din_in = 1'b1;
        wait_rply(1'b1, cnt);
        v  = bus.pin_ad_out;
        en = bus.pin_ad_ena;
        bus.pin_din_in = 1'b0;
        wait_rply(1'b0, m);
        chk("rd_rply_drop", 32'(m != 0), 32'd1);
        chk("rd_ena_drop", 32'(bus.pin_ad_ena), 32'd0);
        bus.pin_sync_in = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        dclo            = 1'b1;
        irq_req         = 1'b0;
        bus.pin_init    = 1'b0;
        bus.pin_ad_in   = 16'h0;
        bus.pin_sync_in = 1'b0;
        bus.pin_din_in  = 1'b0;
        bus.pin_dout_in = 1'b0;
        bus.pin_wtbt_in = 1'b0;
        bus.pin_iako_in = 1'b0;
        tick();
        tick();
        dclo = 1'b0;
        tick();

        chk("rst_rply", 32'(bus.pin_rply_out), 32'd0);
        chk("rst_ena", 32'(bus.pin_ad_ena), 32'd0);
        chk("rst_virq", 32'(bus.pin_virq_out), 32'd0);
        chk("rst_iako", 32'(bus.pin_iako_out), 32'd0);
        chk("rst_regq", 32'(reg_q != 64'h0), 32'd0);

        // Word write to reg1 (177702): latency, strobe pulse, contents.
        do_write(16'o177702, 16'o012345, 1'b0, n, ws0, ws1);
        chk("wr_latency", 32'(n), 32'(LAT));
        chk("wr_wstb", 32'(ws0), 32'b0010);
        chk("wr_wstb_end", 32'(ws1), 32'b0000);
        chk("wr_reg1", 32'(reg_q[31:16]), 32'o012345);

        do_read(16'o177702, n, d, e);
        chk("rd_latency", 32'(n), 32'(LAT));
        chk("rd_data", 32'(d), 32'o012345);
        chk("rd_ena", 32'(e), 32'd1);

        // High-byte write to 177703 keeps the low byte 0xE5.
        do_write(16'o177703, 16'hAB00, 1'b1, n, ws0, ws1);
        chk("wb_latency", 32'(n), 32'(LAT));
        chk("wb_wstb", 32'(ws0), 32'b0010);
        chk("wb_reg1", 32'(reg_q[31:16]), 32'hABE5);
        chk("wb_reg0", 32'(reg_q[15:0]), 32'h0);
        chk("wb_reg2", 32'(reg_q[47:32]), 32'h0);

        do_write(16'o177704, 16'h00CD, 1'b1, n, ws0, ws1);
        chk("wbl_wstb", 32'(ws0), 32'b0100);
        chk("wbl_reg2", 32'(reg_q[47:32]), 32'h00CD);

        // Unselected address: no reply, no drive for the whole cycle.
        bus.pin_ad_in   = 16'o177600;
        bus.pin_sync_in = 1'b1;
        tick();
        tick();
        bus.pin_ad_in  = 16'h0;
        bus.pin_din_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | bus.pin_rply_out | bus.pin_ad_ena;
        end
        chk("nosel_quiet", 32'(seen), 32'd0);
        bus.pin_din_in  = 1'b0;
        bus.pin_sync_in = 1'b0;
        tick();
        tick();

        // DATIO on reg0: read old value then write under one SYNC.
        do_write(16'o177700, 16'h1234, 1'b0, n, ws0, ws1);
        bus.pin_ad_in   = 16'o177700;
        bus.pin_sync_in = 1'b1;
        tick();
        tick();
        bus.pin_ad_in  = 16'h0;
        bus.pin_din_in = 1'b1;
        wait_rply(1'b1, n);
        chk("dio_rd_lat", 32'(n), 32'(LAT));
        chk("dio_rd_data", 32'(bus.pin_ad_out), 32'h1234);
        bus.pin_din_in = 1'b0;
        wait_rply(1'b0, n2);
        chk("dio_gap", 32'(n2 != 0), 32'd1);
        bus.pin_ad_in   = 16'h5678;
        bus.pin_dout_in = 1'b1;
        wait_rply(1'b1, n);
        chk("dio_wr_lat", 32'(n), 32'(LAT));
        chk("dio_wr_ena", 32'(bus.pin_ad_ena), 32'd0);
        bus.pin_dout_in = 1'b0;
        wait_rply(1'b0, n2);
        bus.pin_sync_in = 1'b0;
        bus.pin_ad_in   = 16'h0;
        tick();
        tick();
        chk("dio_reg0", 32'(reg_q[15:0]), 32'h5678);

        // Interrupt claimed by this slave.
        irq_req = 1'b1;
        tick();
        tick();
        tick();
        chk("irq_virq", 32'(bus.pin_virq_out), 32'd1);
        bus.pin_din_in = 1'b1;
        tick();
        bus.pin_iako_in = 1'b1;
        wait_rply(1'b1, n);
        chk("ack_latency", 32'(n), 32'(LAT));
        chk("ack_vector", 32'(bus.pin_ad_out), 32'o000100);
        chk("ack_ena", 32'(bus.pin_ad_ena), 32'd1);
        chk("ack_iako_out", 32'(bus.pin_iako_out), 32'd0);
        bus.pin_din_in = 1'b0;
        tick();
        tick();
        tick();
        chk("ack_rply_off", 32'(bus.pin_rply_out), 32'd0);
        chk("ack_ena_off", 32'(bus.pin_ad_ena), 32'd0);
        chk("ack_virq_off", 32'(bus.pin_virq_out), 32'd0);
        bus.pin_iako_in = 1'b0;
        irq_req         = 1'b0;
        tick();
        tick();

        // Nothing pending: IAKO passes downstream one clock later.
        bus.pin_din_in = 1'b1;
        tick();
        bus.pin_iako_in = 1'b1;
        chk("pass_before", 32'(bus.pin_iako_out), 32'd0);
        tick();
        chk("pass_follow", 32'(bus.pin_iako_out), 32'd1);
        irq_req = 1'b1;
        tick();
        tick();
        tick();
        chk("pass_virq", 32'(bus.pin_virq_out), 32'd1);
        chk("pass_hold", 32'(bus.pin_iako_out), 32'd1);
        chk("pass_norply", 32'(bus.pin_rply_out), 32'd0);
        bus.pin_iako_in = 1'b0;
        tick();
        chk("pass_drop", 32'(bus.pin_iako_out), 32'd0);
        bus.pin_din_in = 1'b0;
        tick();
        tick();

        // INIT while acknowledging the still-pending request.
        bus.pin_din_in = 1'b1;
        tick();
        bus.pin_iako_in = 1'b1;
        wait_rply(1'b1, n);
        chk("ack2_latency", 32'(n), 32'(LAT));
        bus.pin_init = 1'b1;
        tick();
        chk("init_rply", 32'(bus.pin_rply_out), 32'd0);
        chk("init_ena", 32'(bus.pin_ad_ena), 32'd0);
        chk("init_virq", 32'(bus.pin_virq_out), 32'd0);
        chk("init_regq", 32'(reg_q != 64'h0), 32'd0);
        bus.pin_init = 1'b0;
        tick();
        chk("init_quiet", 32'(bus.pin_rply_out), 32'd0);
        bus.pin_din_in  = 1'b0;
        bus.pin_iako_in = 1'b0;
        irq_req         = 1'b0;
        tick();
        tick();

        // DCLO in the middle of a read clears outputs without a clock edge.
        irq_req = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_dclo_virq", 32'(bus.pin_virq_out), 32'd1);
        do_write(16'o177702, 16'o012345, 1'b0, n, ws0, ws1);
        bus.pin_ad_in   = 16'o177702;
        bus.pin_sync_in = 1'b1;
        tick();
        tick();
        bus.pin_ad_in  = 16'h0;
        bus.pin_din_in = 1'b1;
        wait_rply(1'b1, n);
        chk("pre_dclo_data", 32'(bus.pin_ad_out), 32'o012345);
        #2;
        dclo = 1'b1;
        #1;
        chk("dclo_rply", 32'(bus.pin_rply_out), 32'd0);
        chk("dclo_ena", 32'(bus.pin_ad_ena), 32'd0);
        chk("dclo_virq", 32'(bus.pin_virq_out), 32'd0);
        chk("dclo_iako", 32'(bus.pin_iako_out), 32'd0);
        chk("dclo_regq", 32'(reg_q != 64'h0), 32'd0);
        bus.pin_din_in  = 1'b0;
        bus.pin_sync_in = 1'b0;
        irq_req         = 1'b0;
        tick();
        dclo = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
